alu_issue: RTL

Command issue and result capture stage that sits directly upstream of the combinational `alu`. It accepts `{op, a, b}` commands over a valid/ready handshake into a small FIFO. It drives one command at a time onto registered ALU operand and opcode lines, then captures the ALU result into a held output register with its own valid/ready handshake. It is the sequential wrapper the datapath uses to pace work through the ALU.

---
 rtl/alu_issue_if.sv | 28 ++
 rtl/alu_issue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Handshake bundle between a command producer / result consumer and alu_issue.
// The slave modport is the alu_issue side; the master modport is the client side.
interface alu_issue_if #(
    parameter int len_A = 3,
    parameter int len_B = 3,
    parameter int len_F = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [len_A-1:0] in_a;
    logic [len_B-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [len_F-1:0] out_f;
    logic [2:0]       out_op;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_f, out_op, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_f, out_op, out_err
    );
endinterface

// File: rtl/alu_issue.sv
// Command issue and result capture stage in front of the combinational alu.
// Commands are queued in a small FIFO, issued one at a time on registered
// operand/opcode lines, and the alu result is held until the consumer takes it.
module alu_issue #(
    parameter int len_A = 3,
    parameter int len_B = 3,
    parameter int len_F = 3,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    alu_issue_if.slave                 bus,
    output logic [len_A-1:0]           o_alu_a,
    output logic [len_B-1:0]           o_alu_b,
    output logic [2:0]                 o_alu_op,
    input  logic [len_F-1:0]           i_alu_f,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [len_A-1:0] r_alu_a;
    logic [len_B-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_out_valid;
    logic [len_F-1:0] r_out_f;
    logic [2:0]       r_out_op;
    logic             r_out_err;

    logic [2:0]       r_mem_op [DEPTH];
    logic [len_A-1:0] r_mem_a  [DEPTH];
    logic [len_B-1:0] r_mem_b  [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_nempty;

    // FIFO accepts while not full; derived only from the registered count.
    assign w_in_ready    = (r_count < CW'(DEPTH));
    assign w_push        = bus.in_valid && w_in_ready;
    assign w_fifo_nempty = (r_count != {CW{1'b0}});

    // Pop decision: the FSM takes the head when it is free to issue a new command.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_fifo_nempty;
            S_HOLD:  w_pop = bus.out_ready && w_fifo_nempty;
            S_ISSUE: w_pop = 1'b0;
            default: w_pop = 1'b0;
        endcase
    end

    // FIFO storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= bus.in_op;
            r_mem_a[r_wr_ptr]  <= bus.in_a;
            r_mem_b[r_wr_ptr]  <= bus.in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue/capture FSM with registered alu operands and held result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_alu_a     <= {len_A{1'b0}};
            r_alu_b     <= {len_B{1'b0}};
            r_alu_op    <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_f     <= {len_F{1'b0}};
            r_out_op    <= 3'd0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu_a  <= r_mem_a[r_rd_ptr];
                        r_alu_b  <= r_mem_b[r_rd_ptr];
                        r_alu_op <= r_mem_op[r_rd_ptr];
                        r_state  <= S_ISSUE;
                    end else begin
                        r_alu_a  <= {len_A{1'b0}};
                        r_alu_b  <= {len_B{1'b0}};
                        r_alu_op <= 3'd0;
                        r_state  <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // Opcode 0 has no defined alu result, so never latch it.
                    r_out_valid <= 1'b1;
                    r_out_op    <= r_alu_op;
                    if (r_alu_op != 3'd0) begin
                        r_out_f   <= i_alu_f;
                        r_out_err <= 1'b0;
                    end else begin
                        r_out_f   <= {len_F{1'b0}};
                        r_out_err <= 1'b1;
                    end
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_a  <= r_mem_a[r_rd_ptr];
                            r_alu_b  <= r_mem_b[r_rd_ptr];
                            r_alu_op <= r_mem_op[r_rd_ptr];
                            r_state  <= S_ISSUE;
                        end else begin
                            r_alu_a  <= {len_A{1'b0}};
                            r_alu_b  <= {len_B{1'b0}};
                            r_alu_op <= 3'd0;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_alu_a     <= {len_A{1'b0}};
                    r_alu_b     <= {len_B{1'b0}};
                    r_alu_op    <= 3'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_f     = r_out_f;
    assign bus.out_op    = r_out_op;
    assign bus.out_err   = r_out_err;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_op      = r_alu_op;
    assign o_count       = r_count;
endmodule
